// File: rtl/hall_call_encoder.sv
// Hall-call encoder: captures six hall buttons, latches lamps, and sends each new
// call once as a 3-bit code on din. Define HALL_DEBOUNCE_EN for 4-cycle button debounce.
module hall_call_encoder #(
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] btn,
    input  logic       arrive,
    input  logic [1:0] arrive_floor,
    input  logic       arrive_dir,
    output logic [2:0] din,
    output logic [5:0] lamp,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] din_q, din_d;
    logic [2:0] ptr_q, ptr_d;
    logic [5:0] lamp_q, lamp_d;
    logic [5:0] pend_q, pend_d;
    logic [5:0] q1_q;
    logic [5:0] rise, clr, avail, take;
    logic       sel_vld;
    logic [2:0] sel_idx;

    function automatic logic [2:0] code_of(input logic [2:0] idx);
        case (idx)
            3'd0:    code_of = 3'b001;
            3'd1:    code_of = 3'b010;
            3'd2:    code_of = 3'b011;
            3'd3:    code_of = 3'b110;
            3'd4:    code_of = 3'b111;
            3'd5:    code_of = 3'b100;
            default: code_of = 3'b000;
        endcase
    endfunction

`ifdef HALL_DEBOUNCE_EN
    // Saturates at 4 so a held button produces exactly one rise per press.
    logic [5:0][2:0] db_q, db_d;

    always_comb begin
        db_d = '0;
        rise = '0;
        for (int i = 0; i < 6; i++) begin
            db_d[i] = !q1_q[i] ? 3'd0 : (db_q[i] == 3'd4 ? 3'd4 : db_q[i] + 3'd1);
            rise[i] = q1_q[i] && (db_q[i] == 3'd3);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) db_q <= '0;
        else     db_q <= db_d;
    end
`else
    logic [5:0] q2_q;

    assign rise = q1_q & ~q2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q2_q <= '0;
        else     q2_q <= q1_q;
    end
`endif

    always_comb begin
        clr = '0;
        if (arrive) begin
            case (arrive_floor)
                2'd0: clr[0] = 1'b1;
                2'd1: clr[arrive_dir ? 3 : 1] = 1'b1;
                2'd2: clr[arrive_dir ? 4 : 2] = 1'b1;
                default: clr[5] = 1'b1;
            endcase
        end
    end

    // Calls cleared this cycle are excluded so a cancelled call is never picked.
    assign avail = pend_q & ~clr;

    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = 0; k < 6; k++) begin
            if (!sel_vld && avail[(int'(ptr_q) + k) % 6]) begin
                sel_vld = 1'b1;
                sel_idx = 3'((int'(ptr_q) + k) % 6);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        din_d   = '0;
        ptr_d   = ptr_q;
        take    = '0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d       = SEND;
                    cnt_d         = 4'(HOLD_CYCLES - 1);
                    din_d         = code_of(sel_idx);
                    ptr_d         = (sel_idx == 3'd5) ? 3'd0 : sel_idx + 3'd1;
                    take[sel_idx] = 1'b1;
                end
            end
            SEND: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                    cnt_d   = 4'(GAP_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    din_d = din_q;
                end
            end
            default: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 4'd1;
            end
        endcase
    end

    assign lamp_d = (lamp_q | rise) & ~clr;
    assign pend_d = (pend_q | (rise & ~lamp_q)) & ~clr & ~take;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            din_q   <= '0;
            ptr_q   <= '0;
            lamp_q  <= '0;
            pend_q  <= '0;
            q1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            ptr_q   <= ptr_d;
            lamp_q  <= lamp_d;
            pend_q  <= pend_d;
            q1_q    <= btn;
        end
    end

    assign din  = din_q;
    assign lamp = lamp_q;
    assign busy = (state_q != IDLE) | (|pend_q);

endmodule

// File: tb/tb_hall_call_encoder.sv
// Randomized and directed bench for hall_call_encoder against a call-list model.
module tb_hall_call_encoder;

    localparam int HOLD   = 2;
    localparam int GAP    = 1;
    localparam int PERIOD = HOLD + GAP + 1;
`ifdef HALL_DEBOUNCE_EN
    localparam int DB    = 3;
    localparam int PRESS = 5;
`else
    localparam int DB    = 0;
    localparam int PRESS = 1;
`endif
    localparam logic [2:0] CODE [6] = '{3'b001, 3'b010, 3'b011, 3'b110, 3'b111, 3'b100};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] btn = '0;
    logic       arrive = 1'b0;
    logic [1:0] arrive_floor = '0;
    logic       arrive_dir = 1'b0;
    logic [2:0] din;
    logic [5:0] lamp;
    logic       busy;

    int errors = 0;
    int checks = 0;
    logic [2:0] got [$];

    hall_call_encoder #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .btn(btn), .arrive(arrive), .arrive_floor(arrive_floor),
        .arrive_dir(arrive_dir), .din(din), .lamp(lamp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        btn = '0; arrive = 1'b0; rst = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic press(input logic [5:0] mask);
        btn = mask;
        repeat (PRESS) step();
        btn = '0;
    endtask

    task automatic collect(input int n);
        logic [2:0] prev;
        got.delete();
        prev = din;
        repeat (n) begin
            step();
            if (din != 3'b000 && prev == 3'b000) got.push_back(din);
            prev = din;
        end
    endtask

    task automatic pulse_arrive(input logic [1:0] fl, input logic dir);
        arrive = 1'b1; arrive_floor = fl; arrive_dir = dir;
        step();
        arrive = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (din !== 3'b000 || lamp !== 6'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset: din=%b lamp=%b busy=%b, want 000/000000/0", din, lamp, busy);
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [2:0] ed;
        logic [5:0] el;
        logic       eb;
        do_reset();
        btn = 6'b000100;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 3 + DB) btn = '0;
            el = (k >= 2 + DB) ? 6'b000100 : 6'b0;
            ed = (k >= 3 + DB && k <= 2 + DB + HOLD) ? 3'b011 : 3'b000;
            eb = (k >= 2 + DB && k <= 2 + DB + HOLD + GAP);
            checks++;
            if (din !== ed || lamp !== el || busy !== eb) begin
                errors++;
                $display("FAIL single k=%0d: din=%b lamp=%b busy=%b, want %b %b %b",
                         k, din, lamp, busy, ed, el, eb);
            end
        end
    endtask

    task automatic test_all();
        logic [2:0] ed;
        int t;
        do_reset();
        btn = 6'b111111;
        for (int k = 1; k <= 3 + DB + 6 * PERIOD + 2; k++) begin
            step();
            if (k == PRESS) btn = '0;
            t  = k - (3 + DB);
            ed = (t >= 0 && t < 6 * PERIOD && (t % PERIOD) < HOLD) ? CODE[t / PERIOD] : 3'b000;
            checks++;
            if (din !== ed) begin
                errors++;
                $display("FAIL all_din k=%0d: got %b want %b", k, din, ed);
            end
            if (k >= 2 + DB) begin
                checks++;
                if (lamp !== 6'b111111) begin
                    errors++;
                    $display("FAIL all_lamp k=%0d: got %b want 111111", k, lamp);
                end
            end
        end
    endtask

    task automatic test_relight();
        do_reset();
        press(6'b010000);
        collect(30);
        checks++;
        if (got.size() != 1 || got[0] !== 3'b111) begin
            errors++;
            $display("FAIL relight_first: sent %0d codes, want one 111", got.size());
        end
        press(6'b010000);
        collect(30);
        checks++;
        if (got.size() != 0 || lamp[4] !== 1'b1) begin
            errors++;
            $display("FAIL relight_ignored: sent %0d codes lamp=%b, want 0 codes lamp[4]=1",
                     got.size(), lamp);
        end
        pulse_arrive(2'd2, 1'b1);
        checks++;
        if (lamp[4] !== 1'b0) begin
            errors++;
            $display("FAIL relight_clear: lamp=%b, want lamp[4]=0", lamp);
        end
        press(6'b010000);
        collect(30);
        checks++;
        if (got.size() != 1 || got[0] !== 3'b111) begin
            errors++;
            $display("FAIL relight_resend: sent %0d codes, want one 111", got.size());
        end
    endtask

    task automatic test_arrive_cancel();
        do_reset();
        btn = 6'b100010;
        for (int k = 1; k <= 3 + DB; k++) begin
            step();
            if (k == PRESS) btn = '0;
            if (k == 2 + DB) begin
                arrive = 1'b1; arrive_floor = 2'd3; arrive_dir = 1'b0;
            end
        end
        arrive = 1'b0;
        checks++;
        if (din !== 3'b010 || lamp !== 6'b000010) begin
            errors++;
            $display("FAIL cancel_send: din=%b lamp=%b, want 010 000010", din, lamp);
        end
        collect(30);
        checks++;
        if (got.size() != 0 || lamp !== 6'b000010 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cancel_after: extra=%0d lamp=%b busy=%b, want 0 000010 0",
                     got.size(), lamp, busy);
        end
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        btn = 6'b000001;
        for (int k = 1; k <= 3 + DB; k++) begin
            step();
            if (k == PRESS) btn = '0;
        end
        checks++;
        if (din !== 3'b001) begin
            errors++;
            $display("FAIL midrst_pre: din=%b want 001", din);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (din !== 3'b000 || lamp !== 6'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: din=%b lamp=%b busy=%b, want 0", din, lamp, busy);
        end
        step();
        rst = 1'b0;
        collect(20);
        checks++;
        if (got.size() != 0 || lamp !== 6'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_after: codes=%0d lamp=%b busy=%b, want none", got.size(), lamp, busy);
        end
    endtask

    // Model: a press of several unlit buttons yields their codes in index order
    // starting from the slot after the last call sent.
    task automatic test_random();
        logic [5:0] lamp_m, fresh, cmask;
        logic [2:0] exp_q [$];
        int ptr_m, last, fl, dir;
        do_reset();
        lamp_m = '0;
        ptr_m  = 0;
        for (int it = 0; it < 10; it++) begin
            logic [5:0] mask;
            mask = 6'($urandom_range(1, 63));
            fresh = mask & ~lamp_m;
            exp_q.delete();
            last = -1;
            for (int k = 0; k < 6; k++) begin
                if (fresh[(ptr_m + k) % 6]) begin
                    exp_q.push_back(CODE[(ptr_m + k) % 6]);
                    last = (ptr_m + k) % 6;
                end
            end
            if (last >= 0) ptr_m = (last + 1) % 6;
            lamp_m |= mask;
            press(mask);
            collect(6 * PERIOD + 8);
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand_count it=%0d: got %0d codes want %0d", it, got.size(), exp_q.size());
            end else begin
                for (int i = 0; i < got.size(); i++) begin
                    checks++;
                    if (got[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand_code it=%0d #%0d: got %b want %b", it, i, got[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (lamp !== lamp_m || busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_lamp it=%0d: lamp=%b busy=%b want %b 0", it, lamp, busy, lamp_m);
            end
            fl  = $urandom_range(0, 3);
            dir = $urandom_range(0, 1);
            cmask = '0;
            if (fl == 0)      cmask = 6'b000001;
            else if (fl == 3) cmask = 6'b100000;
            else if (fl == 1) cmask = dir ? 6'b001000 : 6'b000010;
            else              cmask = dir ? 6'b010000 : 6'b000100;
            lamp_m &= ~cmask;
            pulse_arrive(2'(fl), 1'(dir));
            checks++;
            if (lamp !== lamp_m) begin
                errors++;
                $display("FAIL rand_arrive it=%0d fl=%0d dir=%0d: lamp=%b want %b", it, fl, dir, lamp, lamp_m);
            end
        end
    endtask

`ifdef HALL_DEBOUNCE_EN
    task automatic test_debounce();
        do_reset();
        btn = 6'b000001;
        collect(3);
        btn = '0;
        collect(20);
        checks++;
        if (lamp !== 6'b0 || got.size() != 0) begin
            errors++;
            $display("FAIL debounce_glitch: lamp=%b codes=%0d want none", lamp, got.size());
        end
        btn = 6'b000001;
        collect(5);
        btn = '0;
        collect(20);
        checks++;
        if (lamp !== 6'b000001 || got.size() != 1 || got[0] !== 3'b001) begin
            errors++;
            $display("FAIL debounce_press: lamp=%b codes=%0d want 000001 one 001", lamp, got.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all();
        test_relight();
        test_arrive_cancel();
        test_reset_mid_send();
        test_random();
`ifdef HALL_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
